// File: rtl/bpfvm_pkg.sv
// rtl/bpfvm_pkg.sv - shared BPF transfer-size and packet-buffer state encodings
package bpfvm_pkg;

  localparam logic [1:0] BPF_W    = 2'd0;
  localparam logic [1:0] BPF_H    = 2'd1;
  localparam logic [1:0] BPF_B    = 2'd2;
  localparam logic [1:0] BPF_RSVD = 2'd3;

  typedef enum logic [1:0] {
    BUF_EMPTY   = 2'd0,
    BUF_LOADED  = 2'd1,
    BUF_FORWARD = 2'd2
  } buf_state_t;

  // Byte count of a load; reserved size returns 0 and is flagged out of bounds elsewhere.
  function automatic logic [2:0] xfer_bytes(input logic [1:0] sz);
    case (sz)
      BPF_W:   xfer_bytes = 3'd4;
      BPF_H:   xfer_bytes = 3'd2;
      BPF_B:   xfer_bytes = 3'd1;
      default: xfer_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/bpfvm_pktmem_bank.sv
// rtl/bpfvm_pktmem_bank.sv - 1W/1R synchronous simple-dual-port 32-bit RAM bank
module bpfvm_pktmem_bank #(
  parameter int ROW_WIDTH = 7
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ROW_WIDTH-1:0] waddr,
  input  logic [31:0]          wdata,
  input  logic                 re,
  input  logic [ROW_WIDTH-1:0] raddr,
  output logic [31:0]          rdata
);

  logic [31:0] mem [0:(1<<ROW_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/bpfvm_packet_buf.sv
// rtl/bpfvm_packet_buf.sv - single-packet buffer between snooper, BPF CPU and forwarder
module bpfvm_packet_buf
  import bpfvm_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-3:0] wr_addr,
  input  logic [31:0]           wr_data,
  input  logic                  wr_done,
  input  logic [ADDR_WIDTH:0]   wr_len,
  output logic                  wr_ready,
  output logic                  mem_ready,
  input  logic                  cpu_rd_en,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [1:0]            transfer_sz,
  output logic [31:0]           cpu_rd_data,
  output logic                  cpu_oob,
  output logic [ADDR_WIDTH:0]   pkt_len,
  input  logic                  accept,
  input  logic                  reject,
  output logic                  fwd_pending,
  input  logic                  fwd_rd_en,
  input  logic [ADDR_WIDTH-3:0] fwd_addr,
  output logic [31:0]           fwd_rd_data,
  input  logic                  fwd_done
);

  localparam int WW = ADDR_WIDTH - 2;
  localparam int RW = ADDR_WIDTH - 3;

  buf_state_t state, state_n;

  logic wr_acc, cpu_acc, fwd_acc;
  assign wr_acc  = wr_en && (state == BUF_EMPTY);
  assign cpu_acc = cpu_rd_en && (state == BUF_LOADED);
  assign fwd_acc = fwd_rd_en && (state == BUF_FORWARD);

  always_comb begin
    state_n = state;
    case (state)
      BUF_EMPTY:   if (wr_done) state_n = BUF_LOADED;
      BUF_LOADED: begin
        if (reject)      state_n = BUF_EMPTY;
        else if (accept) state_n = BUF_FORWARD;
      end
      BUF_FORWARD: if (fwd_done) state_n = BUF_EMPTY;
      default:     state_n = BUF_EMPTY;
    endcase
  end

  // CPU window: word w and w+1 always sit in opposite banks, so one cycle reads both.
  logic [WW-1:0] cpu_w, cpu_w1;
  logic [RW-1:0] even_raddr, odd_raddr;
  assign cpu_w  = cpu_addr[ADDR_WIDTH-1:2];
  assign cpu_w1 = cpu_w + {{(WW-1){1'b0}}, 1'b1};

  always_comb begin
    even_raddr = cpu_w1[WW-1:1];
    odd_raddr  = cpu_w[WW-1:1];
    if (state == BUF_FORWARD) begin
      even_raddr = fwd_addr[WW-1:1];
      odd_raddr  = fwd_addr[WW-1:1];
    end
  end

  logic [31:0] even_rd, odd_rd;

  bpfvm_pktmem_bank #(.ROW_WIDTH(RW)) u_bank_even (
    .clk   (clk),
    .we    (wr_acc && !wr_addr[0]),
    .waddr (wr_addr[WW-1:1]),
    .wdata (wr_data),
    .re    (cpu_acc || fwd_acc),
    .raddr (even_raddr),
    .rdata (even_rd)
  );

  bpfvm_pktmem_bank #(.ROW_WIDTH(RW)) u_bank_odd (
    .clk   (clk),
    .we    (wr_acc && wr_addr[0]),
    .waddr (wr_addr[WW-1:1]),
    .wdata (wr_data),
    .re    (cpu_acc || fwd_acc),
    .raddr (odd_raddr),
    .rdata (odd_rd)
  );

  // Bounds check is one bit wider than a full-buffer length so a+n never overflows.
  logic [ADDR_WIDTH+1:0] load_end;
  logic                  oob_n;
  assign load_end = {2'b00, cpu_addr} + {{(ADDR_WIDTH-1){1'b0}}, xfer_bytes(transfer_sz)};
  assign oob_n    = (transfer_sz == BPF_RSVD) || (load_end > {1'b0, pkt_len});

  logic        cpu_vld, cpu_swap, fwd_vld, fwd_sel;
  logic [1:0]  cpu_off, cpu_sz;
  logic [31:0] cpu_hold, fwd_hold, cpu_extract;
  logic [63:0] window, window_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BUF_EMPTY;
      wr_ready    <= 1'b1;
      mem_ready   <= 1'b0;
      fwd_pending <= 1'b0;
      pkt_len     <= '0;
      cpu_oob     <= 1'b0;
      cpu_vld     <= 1'b0;
      cpu_swap    <= 1'b0;
      cpu_off     <= 2'd0;
      cpu_sz      <= BPF_W;
      cpu_hold    <= 32'd0;
      fwd_vld     <= 1'b0;
      fwd_sel     <= 1'b0;
      fwd_hold    <= 32'd0;
    end else begin
      state       <= state_n;
      wr_ready    <= (state_n == BUF_EMPTY);
      mem_ready   <= (state_n == BUF_LOADED);
      fwd_pending <= (state_n == BUF_FORWARD);
      if (state == BUF_EMPTY && wr_done) pkt_len <= wr_len;
      cpu_vld <= cpu_acc;
      if (cpu_acc) begin
        cpu_oob  <= oob_n;
        cpu_swap <= cpu_w[0];
        cpu_off  <= cpu_addr[1:0];
        cpu_sz   <= transfer_sz;
      end
      if (cpu_vld) cpu_hold <= cpu_rd_data;
      fwd_vld <= fwd_acc;
      if (fwd_acc) fwd_sel <= fwd_addr[0];
      if (fwd_vld) fwd_hold <= fwd_rd_data;
    end
  end

  // Data outputs track the bank for the cycle after a read, then hold in a shadow register.
  always_comb begin
    window      = cpu_swap ? {odd_rd, even_rd} : {even_rd, odd_rd};
    window_sh   = window << {cpu_off, 3'b000};
    cpu_extract = 32'd0;
    if (!cpu_oob) begin
      case (cpu_sz)
        BPF_W:   cpu_extract = window_sh[63:32];
        BPF_H:   cpu_extract = {16'd0, window_sh[63:48]};
        BPF_B:   cpu_extract = {24'd0, window_sh[63:56]};
        default: cpu_extract = 32'd0;
      endcase
    end
  end

  assign cpu_rd_data = cpu_vld ? cpu_extract : cpu_hold;
  assign fwd_rd_data = fwd_vld ? (fwd_sel ? odd_rd : even_rd) : fwd_hold;

endmodule

// File: tb/tb_bpfvm_packet_buf.sv
// tb/tb_bpfvm_packet_buf.sv - self-checking directed bench for bpfvm_packet_buf
module tb_bpfvm_packet_buf;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en, wr_done, wr_ready, mem_ready;
  logic [AW-3:0] wr_addr, fwd_addr;
  logic [31:0]   wr_data, cpu_rd_data, fwd_rd_data;
  logic [AW:0]   wr_len, pkt_len;
  logic          cpu_rd_en, cpu_oob, accept, reject, fwd_pending, fwd_rd_en, fwd_done;
  logic [AW-1:0] cpu_addr;
  logic [1:0]    transfer_sz;

  always #5 clk = ~clk;

  bpfvm_packet_buf #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done), .wr_len(wr_len),
    .wr_ready(wr_ready), .mem_ready(mem_ready),
    .cpu_rd_en(cpu_rd_en), .cpu_addr(cpu_addr), .transfer_sz(transfer_sz),
    .cpu_rd_data(cpu_rd_data), .cpu_oob(cpu_oob), .pkt_len(pkt_len),
    .accept(accept), .reject(reject), .fwd_pending(fwd_pending),
    .fwd_rd_en(fwd_rd_en), .fwd_addr(fwd_addr), .fwd_rd_data(fwd_rd_data), .fwd_done(fwd_done)
  );

  typedef struct {
    logic [31:0] data;
    logic        oob;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  mem_model [0:(1<<AW)-1];
  logic [31:0] last_cpu;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference load: gather bytes from the byte model, big-endian.
  task automatic model_load(input int a, input int sz, input int len,
                            output logic [31:0] d, output logic o);
    int n;
    n = (sz == 0) ? 4 : (sz == 1) ? 2 : (sz == 2) ? 1 : 0;
    d = 32'd0;
    o = 1'b0;
    if (sz == 3 || a + n > len) o = 1'b1;
    else for (int i = 0; i < n; i++) d = (d << 8) | 32'(mem_model[(a + i) % (1 << AW)]);
  endtask

  task automatic write_word(input int w, input logic [31:0] d, input logic done, input int len);
    wr_en = 1'b1; wr_addr = w[AW-3:0]; wr_data = d; wr_done = done; wr_len = len[AW:0];
    for (int i = 0; i < 4; i++) mem_model[4*w + i] = d[31-8*i -: 8];
    tick();
    wr_en = 1'b0; wr_done = 1'b0;
  endtask

  task automatic pop_cmp(input string tag, input logic [31:0] obs_d, input logic obs_o, input logic use_oob);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk(tag, obs_d, e.data);
      if (use_oob) chk({tag, "_oob"}, {31'd0, obs_o}, {31'd0, e.oob});
      if (use_oob) last_cpu = e.data;
    end
  endtask

  task automatic cpu_load(input string tag, input int a, input int sz, input int len);
    exp_t e;
    model_load(a, sz, len, e.data, e.oob);
    sb.push_back(e);
    cpu_rd_en = 1'b1; cpu_addr = a[AW-1:0]; transfer_sz = sz[1:0];
    tick();
    cpu_rd_en = 1'b0;
    pop_cmp(tag, cpu_rd_data, cpu_oob, 1'b1);
  endtask

  task automatic cpu_load_const(input string tag, input int a, input int sz,
                                input logic [31:0] d, input logic o);
    exp_t e;
    e.data = d; e.oob = o;
    sb.push_back(e);
    cpu_rd_en = 1'b1; cpu_addr = a[AW-1:0]; transfer_sz = sz[1:0];
    tick();
    cpu_rd_en = 1'b0;
    pop_cmp(tag, cpu_rd_data, cpu_oob, 1'b1);
  endtask

  task automatic fwd_read(input string tag, input int w, input logic [31:0] d);
    exp_t e;
    e.data = d; e.oob = 1'b0;
    sb.push_back(e);
    fwd_rd_en = 1'b1; fwd_addr = w[AW-3:0];
    tick();
    fwd_rd_en = 1'b0;
    pop_cmp(tag, fwd_rd_data, 1'b0, 1'b0);
  endtask

  task automatic reload16();
    wr_done = 1'b1; wr_len = 11'd16;
    tick();
    wr_done = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_ready"}, {31'd0, wr_ready}, 32'd1);
    chk({tag, "_mem_ready"}, {31'd0, mem_ready}, 32'd0);
    chk({tag, "_fwd_pending"}, {31'd0, fwd_pending}, 32'd0);
    chk({tag, "_pkt_len"}, 32'(pkt_len), 32'd0);
    chk({tag, "_cpu_rd_data"}, cpu_rd_data, 32'd0);
    chk({tag, "_cpu_oob"}, {31'd0, cpu_oob}, 32'd0);
    chk({tag, "_fwd_rd_data"}, fwd_rd_data, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 0; wr_addr = 0; wr_data = 0; wr_done = 0; wr_len = 0;
    cpu_rd_en = 0; cpu_addr = 0; transfer_sz = 0; accept = 0; reject = 0;
    fwd_rd_en = 0; fwd_addr = 0; fwd_done = 0; last_cpu = 0;
    for (int i = 0; i < (1 << AW); i++) mem_model[i] = 8'h00;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk_reset_outputs("reset");

    write_word(0, 32'h00112233, 1'b0, 0);
    write_word(1, 32'h44556677, 1'b0, 0);
    write_word(2, 32'h8899AABB, 1'b0, 0);
    write_word(3, 32'hCCDDEEFF, 1'b1, 16);
    chk("load_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("load_mem_ready", {31'd0, mem_ready}, 32'd1);
    chk("load_pkt_len", 32'(pkt_len), 32'd16);

    cpu_load_const("ld5_w", 5, 0, 32'h55667788, 1'b0);
    cpu_load_const("ld3_h", 3, 1, 32'h00003344, 1'b0);
    cpu_load_const("ld15_b", 15, 2, 32'h000000FF, 1'b0);
    cpu_load_const("ld0_w", 0, 0, 32'h00112233, 1'b0);
    tick();
    chk("ld_hold", cpu_rd_data, last_cpu);
    cpu_load_const("oob13_w", 13, 0, 32'h0, 1'b1);
    cpu_load_const("ld12_w", 12, 0, 32'hCCDDEEFF, 1'b0);
    cpu_load_const("oob_sz3", 0, 3, 32'h0, 1'b1);
    cpu_load("ld6_h_model", 6, 1, 16);

    wr_en = 1'b1; wr_addr = 0; wr_data = 32'hDEADBEEF; wr_done = 1'b1; wr_len = 11'd8;
    tick();
    wr_en = 1'b0; wr_done = 1'b0;
    chk("prot_loaded_len", 32'(pkt_len), 32'd16);
    cpu_load_const("prot_loaded_ram", 0, 0, 32'h00112233, 1'b0);

    reject = 1'b1;
    tick();
    reject = 1'b0;
    chk("reject_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("reject_mem_ready", {31'd0, mem_ready}, 32'd0);
    cpu_rd_en = 1'b1; cpu_addr = 10'd4; transfer_sz = 2'd0;
    tick();
    cpu_rd_en = 1'b0;
    chk("ignored_cpu_rd", cpu_rd_data, last_cpu);

    reload16();
    accept = 1'b1;
    tick();
    accept = 1'b0;
    chk("accept_fwd_pending", {31'd0, fwd_pending}, 32'd1);
    chk("accept_mem_ready", {31'd0, mem_ready}, 32'd0);
    wr_en = 1'b1; wr_addr = 0; wr_data = 32'hDEADBEEF; wr_done = 1'b1; wr_len = 11'd8;
    tick();
    wr_en = 1'b0; wr_done = 1'b0;
    chk("prot_fwd_len", 32'(pkt_len), 32'd16);
    fwd_read("fwd_w2", 2, 32'h8899AABB);
    fwd_read("fwd_w0", 0, 32'h00112233);
    fwd_read("fwd_w1", 1, 32'h44556677);
    fwd_done = 1'b1;
    tick();
    fwd_done = 1'b0;
    chk("fwd_done_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("fwd_done_pending", {31'd0, fwd_pending}, 32'd0);

    reload16();
    accept = 1'b1; reject = 1'b1;
    tick();
    accept = 1'b0; reject = 1'b0;
    chk("acc_rej_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("acc_rej_pending", {31'd0, fwd_pending}, 32'd0);

    reload16();
    accept = 1'b1;
    tick();
    accept = 1'b0;
    fwd_read("fwd_w3", 3, 32'hCCDDEEFF);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_rst");
    tick();
    rst_n = 1'b1;
    tick();

    for (int w = 0; w < (1 << (AW-2)); w++) begin
      logic [7:0] b;
      b = w[7:0];
      write_word(w, {b, b ^ 8'h5A, ~b, b + 8'd1}, (w == (1 << (AW-2)) - 1), 1 << AW);
    end
    chk("full_pkt_len", 32'(pkt_len), 32'(1 << AW));
    cpu_load("full_last_b", (1 << AW) - 1, 2, 1 << AW);
    cpu_load("full_last_w", (1 << AW) - 4, 0, 1 << AW);
    cpu_load("full_last_h", (1 << AW) - 2, 1, 1 << AW);
    cpu_load("full_oob_w", (1 << AW) - 3, 0, 1 << AW);
    cpu_load("full_cross_w", 511, 0, 1 << AW);
    cpu_load("full_b_mid", 258, 2, 1 << AW);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
